exu_lsu_agu: RTL and testbench



---
 rtl/exu_lsu_agu_if.sv | 40 ++++
 rtl/exu_lsu_agu.sv | 168 ++++++++++++++++
 tb/tb_exu_lsu_agu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_agu_if.sv
// rtl/exu_lsu_agu_if.sv - EXU request, data-memory bus and response signals of the load/store AGU
interface exu_lsu_agu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_req_valid;
   logic                  o_req_ready;
   logic                  i_is_store;
   logic [1:0]            i_size;
   logic                  i_unsigned;
   logic [ADDR_W-1:0]     i_base;
   logic [ADDR_W-1:0]     i_offset;
   logic [DATA_W-1:0]     i_wdata;
   logic                  o_mem_req;
   logic                  i_mem_gnt;
   logic                  o_mem_we;
   logic [ADDR_W-1:0]     o_mem_addr;
   logic [DATA_W/8-1:0]   o_mem_be;
   logic [DATA_W-1:0]     o_mem_wdata;
   logic                  i_mem_rvalid;
   logic [DATA_W-1:0]     i_mem_rdata;
   logic                  o_rsp_valid;
   logic [DATA_W-1:0]     o_rsp_rdata;
   logic                  o_rsp_misalign;
   logic [ADDR_W-1:0]     o_rsp_addr;

   modport slave (
      input  i_req_valid, i_is_store, i_size, i_unsigned, i_base, i_offset, i_wdata,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
      output o_req_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
      output o_rsp_valid, o_rsp_rdata, o_rsp_misalign, o_rsp_addr
   );

   modport master (
      output i_req_valid, i_is_store, i_size, i_unsigned, i_base, i_offset, i_wdata,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
      input  o_req_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
      input  o_rsp_valid, o_rsp_rdata, o_rsp_misalign, o_rsp_addr
   );
endinterface

// File: rtl/exu_lsu_agu.sv
// rtl/exu_lsu_agu.sv - load/store address generation with a single-outstanding data-memory transaction
// Define LSU_MISALIGN_TRAP_EN to complete misaligned/illegal-size ops without touching the bus.
module exu_lsu_agu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   exu_lsu_agu_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int LSB_W = $clog2(BE_W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic [1:0]        state;
   logic [ADDR_W-1:0] ea;
   logic [LSB_W-1:0]  lane_raw;
   logic [LSB_W-1:0]  lane;
   logic [LSB_W-1:0]  size_mask;
   logic [1:0]        size_eff;
   logic              illegal;
   logic              misalign;
   logic [BE_W-1:0]   be_base;
   logic [DATA_W-1:0] wdata_rep;

   logic [ADDR_W-1:0] ea_q;
   logic [LSB_W-1:0]  lane_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic              store_q;
   logic              misalign_q;
   logic [DATA_W-1:0] load_shift;
   logic [DATA_W-1:0] load_ext;
   logic              sign_bit;
   int                nbits;

   // Illegal dword on a 32-bit bus is downgraded to a word; the lane is then forced to natural alignment.
   always_comb begin
      ea        = bus.i_base + bus.i_offset;
      lane_raw  = ea[LSB_W-1:0];
      illegal   = (DATA_W == 32) && (bus.i_size == 2'd3);
      size_eff  = illegal ? 2'd2 : bus.i_size;
      size_mask = LSB_W'((32'd1 << size_eff) - 32'd1);
      misalign  = illegal || ((lane_raw & size_mask) != '0);
      lane      = lane_raw & ~size_mask;
      case (size_eff)
         2'd0:    be_base = BE_W'(8'h01);
         2'd1:    be_base = BE_W'(8'h03);
         2'd2:    be_base = BE_W'(8'h0F);
         default: be_base = BE_W'(8'hFF);
      endcase
   end

   always_comb begin
      wdata_rep = '0;
      for (int b = 0; b < BE_W; b++) begin
         case (size_eff)
            2'd0:    wdata_rep[8*b +: 8] = bus.i_wdata[7:0];
            2'd1:    wdata_rep[8*b +: 8] = bus.i_wdata[8*(b%2) +: 8];
            2'd2:    wdata_rep[8*b +: 8] = bus.i_wdata[8*(b%4) +: 8];
            default: wdata_rep[8*b +: 8] = bus.i_wdata[8*b +: 8];
         endcase
      end
   end

   always_comb begin
      load_shift = bus.i_mem_rdata >> {lane_q, 3'b000};
      nbits      = 8 << size_q;
      case (size_q)
         2'd0:    sign_bit = load_shift[7];
         2'd1:    sign_bit = load_shift[15];
         2'd2:    sign_bit = load_shift[31];
         default: sign_bit = load_shift[DATA_W-1];
      endcase
      sign_bit = sign_bit & ~unsigned_q;
      load_ext = '0;
      for (int i = 0; i < DATA_W; i++)
         load_ext[i] = (i < nbits) ? load_shift[i] : sign_bit;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state              <= S_IDLE;
         ea_q               <= '0;
         lane_q             <= '0;
         size_q             <= '0;
         unsigned_q         <= 1'b0;
         store_q            <= 1'b0;
         misalign_q         <= 1'b0;
         bus.o_req_ready    <= 1'b1;
         bus.o_mem_req      <= 1'b0;
         bus.o_mem_we       <= 1'b0;
         bus.o_mem_addr     <= '0;
         bus.o_mem_be       <= '0;
         bus.o_mem_wdata    <= '0;
         bus.o_rsp_valid    <= 1'b0;
         bus.o_rsp_rdata    <= '0;
         bus.o_rsp_misalign <= 1'b0;
         bus.o_rsp_addr     <= '0;
      end else begin
         bus.o_rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_req_valid) begin
                  ea_q            <= ea;
                  lane_q          <= lane;
                  size_q          <= size_eff;
                  unsigned_q      <= bus.i_unsigned;
                  store_q         <= bus.i_is_store;
                  misalign_q      <= misalign;
                  bus.o_req_ready <= 1'b0;
                  if (TRAP_EN && misalign) begin
                     state              <= S_DONE;
                     bus.o_rsp_valid    <= 1'b1;
                     bus.o_rsp_rdata    <= '0;
                     bus.o_rsp_misalign <= 1'b1;
                     bus.o_rsp_addr     <= ea;
                  end else begin
                     state           <= S_REQ;
                     bus.o_mem_req   <= 1'b1;
                     bus.o_mem_we    <= bus.i_is_store;
                     bus.o_mem_addr  <= {ea[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                     bus.o_mem_be    <= be_base << lane;
                     bus.o_mem_wdata <= wdata_rep;
                  end
               end
            end
            S_REQ: begin
               if (bus.i_mem_gnt) begin
                  bus.o_mem_req <= 1'b0;
                  if (store_q) begin
                     state              <= S_DONE;
                     bus.o_rsp_valid    <= 1'b1;
                     bus.o_rsp_rdata    <= '0;
                     bus.o_rsp_misalign <= misalign_q;
                     bus.o_rsp_addr     <= ea_q;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (bus.i_mem_rvalid) begin
                  state              <= S_DONE;
                  bus.o_rsp_valid    <= 1'b1;
                  bus.o_rsp_rdata    <= load_ext;
                  bus.o_rsp_misalign <= misalign_q;
                  bus.o_rsp_addr     <= ea_q;
               end
            end
            default: begin
               state           <= S_IDLE;
               bus.o_req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exu_lsu_agu.sv
// tb/tb_exu_lsu_agu.sv - scoreboard bench for exu_lsu_agu (32-bit bus)
module tb_exu_lsu_agu;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct {
      logic        st;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] base;
      logic [31:0] off;
      logic [31:0] wdata;
      int          stall;
      int          rvd;
      logic [31:0] rdata;
      logic        has_bus;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic        e_mis;
      logic [31:0] e_ea;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic [31:0] addr;
      int          cyc;
   } rsp_t;

   logic i_clk = 1'b0;
   logic i_rst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   vec_t vecs[$];
   bus_t bus_q[$];
   rsp_t rsp_q[$];
   bus_t b;
   rsp_t r;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   exu_lsu_agu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   exu_lsu_agu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bus fields are checked on every request cycle, so a stall also checks stability.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (bus.o_mem_req) begin
            if (bus_q.size() == 0) check("unexpected_mem_req", 1, 0);
            else begin
               b = bus_q[0];
               check("mem_addr", bus.o_mem_addr, b.addr);
               check("mem_we", bus.o_mem_we, b.we);
               check("mem_be", bus.o_mem_be, b.be);
               check("mem_wdata", bus.o_mem_wdata, b.wdata);
               if (bus.i_mem_gnt) void'(bus_q.pop_front());
            end
         end
         if (bus.o_rsp_valid) begin
            if (rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
            else begin
               r = rsp_q.pop_front();
               check("rsp_rdata", bus.o_rsp_rdata, r.rdata);
               check("rsp_misalign", bus.o_rsp_misalign, r.mis);
               check("rsp_addr", bus.o_rsp_addr, r.addr);
               check("rsp_cycle", cyc, r.cyc);
            end
         end
      end
   end

   task automatic add(input logic st, input logic [1:0] sz, input logic un,
                      input logic [31:0] base, input logic [31:0] off, input logic [31:0] wdata,
                      input int stall, input int rvd, input logic [31:0] rdata, input logic has_bus,
                      input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                      input logic [31:0] e_rdata, input logic e_mis, input logic [31:0] e_ea, input int lat);
      vec_t v;
      v = '{st, sz, un, base, off, wdata, stall, rvd, rdata, has_bus,
            e_addr, e_be, e_wdata, e_rdata, e_mis, e_ea, lat};
      vecs.push_back(v);
   endtask

   task automatic run_op(input vec_t v);
      int n;
      @(posedge i_clk); #1;
      check("req_ready_before_op", bus.o_req_ready, 1);
      bus.i_is_store  = v.st;
      bus.i_size      = v.sz;
      bus.i_unsigned  = v.un;
      bus.i_base      = v.base;
      bus.i_offset    = v.off;
      bus.i_wdata     = v.wdata;
      bus.i_req_valid = 1'b1;
      n = cyc;
      if (v.has_bus) bus_q.push_back('{v.e_addr, v.st, v.e_be, v.e_wdata});
      rsp_q.push_back('{v.e_rdata, v.e_mis, v.e_ea, n + v.lat});
      @(posedge i_clk); #1;
      bus.i_req_valid = 1'b0;
      if (v.has_bus) begin
         for (int s = 0; s < v.stall; s++) begin @(posedge i_clk); #1; end
         bus.i_mem_gnt = 1'b1;
         @(posedge i_clk); #1;
         bus.i_mem_gnt = 1'b0;
         if (!v.st) begin
            for (int d = 0; d < v.rvd; d++) begin @(posedge i_clk); #1; end
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = v.rdata;
            @(posedge i_clk); #1;
            bus.i_mem_rvalid = 1'b0;
            bus.i_mem_rdata  = '0;
         end
      end
      for (int g = 0; g < 20 && (rsp_q.size() != 0 || !bus.o_req_ready); g++) begin
         @(posedge i_clk); #1;
      end
      check("op_complete", rsp_q.size(), 0);
   endtask

   initial begin
      i_rst = 1'b1;
      bus.i_req_valid = 1'b0; bus.i_is_store = 1'b0; bus.i_size = 2'd0; bus.i_unsigned = 1'b0;
      bus.i_base = '0; bus.i_offset = '0; bus.i_wdata = '0;
      bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_req_ready", bus.o_req_ready, 1);
      check("reset_mem_req", bus.o_mem_req, 0);
      check("reset_mem_we", bus.o_mem_we, 0);
      check("reset_mem_be", bus.o_mem_be, 0);
      check("reset_mem_addr", bus.o_mem_addr, 0);
      check("reset_mem_wdata", bus.o_mem_wdata, 0);
      check("reset_rsp_valid", bus.o_rsp_valid, 0);
      check("reset_rsp_rdata", bus.o_rsp_rdata, 0);
      check("reset_rsp_misalign", bus.o_rsp_misalign, 0);
      check("reset_rsp_addr", bus.o_rsp_addr, 0);
      i_rst = 1'b0;

      //  st sz un base          off           wdata         stl rvd rdata         bus e_addr        be    e_wdata       e_rdata       mis e_ea          lat
      add(0, 2, 0, 32'h00001000, 32'h00000004, 32'h00000000, 0, 0, 32'hDEADBEEF, 1, 32'h00001004, 4'hF, 32'h00000000, 32'hDEADBEEF, 0, 32'h00001004, 3);
      add(1, 0, 0, 32'h00002000, 32'h00000003, 32'h000000A5, 0, 0, 32'h00000000, 1, 32'h00002000, 4'h8, 32'hA5A5A5A5, 32'h00000000, 0, 32'h00002003, 2);
      add(0, 1, 0, 32'h00002000, 32'h00000002, 32'h00000000, 0, 0, 32'h80FF1234, 1, 32'h00002000, 4'hC, 32'h00000000, 32'hFFFF80FF, 0, 32'h00002002, 3);
      add(0, 1, 1, 32'h00002000, 32'h00000002, 32'h00000000, 0, 0, 32'h80FF1234, 1, 32'h00002000, 4'hC, 32'h00000000, 32'h000080FF, 0, 32'h00002002, 3);
      add(0, 2, 0, 32'h00003000, 32'h00000010, 32'h00000000, 3, 1, 32'h12345678, 1, 32'h00003010, 4'hF, 32'h00000000, 32'h12345678, 0, 32'h00003010, 7);
      add(1, 1, 0, 32'h00004000, 32'hFFFFFFFE, 32'hABCD1234, 1, 0, 32'h00000000, 1, 32'h00003FFC, 4'hC, 32'h12341234, 32'h00000000, 0, 32'h00003FFE, 3);
      add(0, 0, 0, 32'h00005001, 32'h00000000, 32'h00000000, 0, 0, 32'h00008000, 1, 32'h00005000, 4'h2, 32'h00000000, 32'hFFFFFF80, 0, 32'h00005001, 3);
      add(0, 0, 1, 32'h00005003, 32'h00000000, 32'h00000000, 0, 2, 32'hF1000000, 1, 32'h00005000, 4'h8, 32'h00000000, 32'h000000F1, 0, 32'h00005003, 5);
      add(1, 2, 0, 32'hFFFFFFFC, 32'h00000008, 32'hCAFEF00D, 0, 0, 32'h00000000, 1, 32'h00000004, 4'hF, 32'hCAFEF00D, 32'h00000000, 0, 32'h00000004, 2);
      add(1, 0, 0, 32'h00009000, 32'h00000001, 32'h1234567E, 0, 0, 32'h00000000, 1, 32'h00009000, 4'h2, 32'h7E7E7E7E, 32'h00000000, 0, 32'h00009001, 2);
`ifdef LSU_MISALIGN_TRAP_EN
      add(0, 2, 0, 32'h00001000, 32'h00000002, 32'h00000000, 0, 0, 32'h11223344, 0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1, 32'h00001002, 1);
      add(1, 3, 0, 32'h00006000, 32'h00000000, 32'h89ABCDEF, 0, 0, 32'h00000000, 0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1, 32'h00006000, 1);
      add(0, 1, 0, 32'h00007001, 32'h00000000, 32'h00000000, 0, 0, 32'hAABBCCDD, 0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1, 32'h00007001, 1);
`else
      add(0, 2, 0, 32'h00001000, 32'h00000002, 32'h00000000, 0, 0, 32'h11223344, 1, 32'h00001000, 4'hF, 32'h00000000, 32'h11223344, 1, 32'h00001002, 3);
      add(1, 3, 0, 32'h00006000, 32'h00000000, 32'h89ABCDEF, 0, 0, 32'h00000000, 1, 32'h00006000, 4'hF, 32'h89ABCDEF, 32'h00000000, 1, 32'h00006000, 2);
      add(0, 1, 0, 32'h00007001, 32'h00000000, 32'h00000000, 0, 0, 32'hAABBCCDD, 1, 32'h00007000, 4'h3, 32'h00000000, 32'hFFFFCCDD, 1, 32'h00007001, 3);
`endif
      foreach (vecs[i]) run_op(vecs[i]);

      // Reset while waiting for read data, then a stale rvalid.
      @(posedge i_clk); #1;
      bus.i_is_store = 1'b0; bus.i_size = 2'd2; bus.i_unsigned = 1'b0;
      bus.i_base = 32'h00008000; bus.i_offset = 32'h0; bus.i_req_valid = 1'b1;
      bus_q.push_back('{32'h00008000, 1'b0, 4'hF, 32'h00000000});
      @(posedge i_clk); #1;
      bus.i_req_valid = 1'b0; bus.i_mem_gnt = 1'b1;
      @(posedge i_clk); #1;
      bus.i_mem_gnt = 1'b0; i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h0BADBAD0;
      check("rst_wait_req_ready", bus.o_req_ready, 1);
      check("rst_wait_mem_req", bus.o_mem_req, 0);
      check("rst_wait_rsp_valid", bus.o_rsp_valid, 0);
      @(posedge i_clk); #1;
      bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;
      check("stale_rvalid_rsp_valid", bus.o_rsp_valid, 0);
      check("stale_rvalid_req_ready", bus.o_req_ready, 1);

      // Reset and request together: nothing accepted.
      i_rst = 1'b1; bus.i_req_valid = 1'b1; bus.i_is_store = 1'b1; bus.i_base = 32'h0000A000;
      @(posedge i_clk); #1;
      i_rst = 1'b0; bus.i_req_valid = 1'b0;
      check("rst_req_req_ready", bus.o_req_ready, 1);
      check("rst_req_mem_req", bus.o_mem_req, 0);
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_req_no_mem_req", bus.o_mem_req, 0);
      check("bus_queue_drained", bus_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
